hs32_sram_arb: RTL

HS32_SRAM_ARB -- requirements
Module: hs32_sram_arb

---
 rtl/hs32_sram_arb.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hs32_sram_arb.sv
// Two-master (CPU / Wishbone) arbiter onto NBANKS banks of 32-bit SRAM built from 16-bit macro pairs.
// Define HS32_SRAM_WB_EN to enable the Wishbone master; otherwise the CPU is the only master.
module hs32_sram_arb #(
    parameter int AW     = 8,
    parameter int NBANKS = 1,
    parameter int RD_LAT = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   cpu_stb,
    input  logic                   cpu_rw,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_dtw,
    output logic [31:0]            cpu_dtr,
    output logic                   cpu_ack,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic [NBANKS-1:0]      sram_cs,
    output logic [3:0]             sram_we,
    output logic [AW-1:0]          sram_addr,
    output logic [31:0]            sram_dtw,
    input  logic [32*NBANKS-1:0]   sram_dtr,
    output logic                   o_fault
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;

    logic [1:0]    r_state;
    logic          r_lastWb;
    logic          r_master;
    logic          r_write;
    logic [AW-1:0] r_word;
    logic [1:0]    r_bank;
    logic [31:0]   r_data;
    logic [3:0]    r_strb;

    logic          w_wbReq;
    logic          w_grantWb;
    logic          w_grant;
    logic [31:0]   w_reqAddr;
    logic [31:0]   w_reqData;
    logic [3:0]    w_reqStrb;
    logic          w_reqWrite;
    logic          w_access;
    logic          w_ack;
    logic          w_inRange;
    logic [31:0]   w_rdSlice;
    logic [31:0]   w_rdData;
    logic          w_unused;

`ifdef HS32_SRAM_WB_EN
    assign w_wbReq  = wbs_cyc_i & wbs_stb_i;
    assign w_unused = &{1'b0, cpu_addr[31:AW+4], cpu_addr[1:0],
                        wbs_adr_i[31:AW+4], wbs_adr_i[1:0]};
`else
    assign w_wbReq  = 1'b0;
    assign w_unused = &{1'b0, cpu_addr[31:AW+4], cpu_addr[1:0], wbs_cyc_i, wbs_stb_i,
                        wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i};
`endif

    // On a tie the master that was not granted last wins.
    assign w_grantWb = w_wbReq & (~cpu_stb | ~r_lastWb);
    assign w_grant   = w_wbReq | cpu_stb;

    always_comb begin
        w_reqAddr  = cpu_addr;
        w_reqData  = cpu_dtw;
        w_reqWrite = cpu_rw;
        w_reqStrb  = cpu_rw ? 4'hF : 4'h0;
`ifdef HS32_SRAM_WB_EN
        if (w_grantWb) begin
            w_reqAddr  = wbs_adr_i;
            w_reqData  = wbs_dat_i;
            w_reqWrite = wbs_we_i;
            w_reqStrb  = wbs_we_i ? wbs_sel_i : 4'h0;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_lastWb <= 1'b1;
            r_master <= 1'b0;
            r_write  <= 1'b0;
            r_word   <= '0;
            r_bank   <= '0;
            r_data   <= '0;
            r_strb   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state  <= S_ACCESS;
                        r_master <= w_grantWb;
                        r_lastWb <= w_grantWb;
                        r_write  <= w_reqWrite;
                        r_word   <= w_reqAddr[AW+1:2];
                        r_bank   <= w_reqAddr[AW+3:AW+2];
                        r_data   <= w_reqData;
                        r_strb   <= w_reqStrb;
                    end
                end
                S_ACCESS: r_state <= (!r_write && RD_LAT >= 2) ? S_WAIT : S_ACK;
                S_WAIT:   r_state <= S_ACK;
                S_ACK:    r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs are gated by reset so the reset cycle itself shows nothing.
    assign w_access  = (r_state == S_ACCESS) && !i_reset;
    assign w_ack     = (r_state == S_ACK) && !i_reset;
    assign w_inRange = int'(r_bank) < NBANKS;

    always_comb begin
        sram_cs   = '0;
        w_rdSlice = '0;
        for (int b = 0; b < NBANKS; b++) begin
            if (int'(r_bank) == b) begin
                sram_cs[b] = w_access;
                w_rdSlice  = sram_dtr[b*32 +: 32];
            end
        end
    end

    assign sram_we   = (w_access && w_inRange) ? r_strb : 4'h0;
    assign sram_addr = w_access ? r_word : '0;
    assign sram_dtw  = w_access ? r_data : 32'h0;
    assign w_rdData  = (w_ack && !r_write) ? w_rdSlice : 32'h0;

    assign cpu_ack = w_ack & ~r_master;
    assign cpu_dtr = r_master ? 32'h0 : w_rdData;
    assign o_fault = w_ack & ~w_inRange;

`ifdef HS32_SRAM_WB_EN
    assign wbs_ack_o = w_ack & r_master;
    assign wbs_dat_o = r_master ? w_rdData : 32'h0;
`else
    assign wbs_ack_o = 1'b0;
    assign wbs_dat_o = 32'h0;
`endif

endmodule
